// File: rtl/ahb_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_pkg
//  Description : Shared types and constants for the AHB transfer sequencer:
//                FSM state encoding, fixed HPROT value, issue-state helper.
//  Revision    : 1.0  initial release
// ============================================================================
package ahb_master_pkg;

  // Sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // HPROT: data access, privileged, non-bufferable, non-cacheable
  localparam logic [3:0] C_XFER_PROT = 4'b0011;

  // Width of the beat-length and beat counters
  localparam int unsigned C_LEN_WDT = 16;

  // States in which the master is enabled and beats may be issued
  function automatic logic is_issue_state(input seq_state_t s);
    return (s == ST_START) || (s == ST_RUN);
  endfunction

endpackage : ahb_master_pkg
`default_nettype wire

// File: rtl/ahb_xfer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_xfer_sequencer_if
//  Description : Bundle of command, write/read stream and AHB-master-side
//                signals of the transfer sequencer. The slave modport is the
//                sequencer view, the master modport the driving-side view.
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_xfer_sequencer_if #(
  parameter int BUS_WDT = 32
);

  // Command channel
  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [31:0]        i_cmd_addr;
  logic [15:0]        i_cmd_len;
  logic               i_cmd_write;
  logic [1:0]         i_cmd_size;

  // Write stream (into the write FIFO)
  logic [BUS_WDT-1:0] i_wr_data;
  logic               i_wr_valid;
  logic               o_wr_ready;

  // Read stream (out of the read FIFO)
  logic [BUS_WDT-1:0] o_rd_data;
  logic               o_rd_valid;
  logic               i_rd_ready;

  // Completion
  logic               o_done;

  // AHB master user interface
  logic [BUS_WDT-1:0] o_xfer_wdata;
  logic [31:0]        o_xfer_addr;
  logic [1:0]         o_xfer_size;
  logic               o_xfer_write;
  logic               o_xfer_dav;
  logic               o_xfer_full;
  logic               o_xfer_trig;
  logic               o_xfer_en;
  logic [3:0]         o_xfer_prot;
  logic               o_xfer_lock;
  logic               i_xfer_adv;
  logic [BUS_WDT-1:0] i_xfer_rdata;
  logic               i_xfer_rdav;
  logic               i_xfer_ok_to_shutdown;

  modport slave (
    input  i_cmd_valid, i_cmd_addr, i_cmd_len, i_cmd_write, i_cmd_size,
    input  i_wr_data, i_wr_valid, i_rd_ready,
    input  i_xfer_adv, i_xfer_rdata, i_xfer_rdav, i_xfer_ok_to_shutdown,
    output o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid, o_done,
    output o_xfer_wdata, o_xfer_addr, o_xfer_size, o_xfer_write,
    output o_xfer_dav, o_xfer_full, o_xfer_trig, o_xfer_en,
    output o_xfer_prot, o_xfer_lock
  );

  modport master (
    output i_cmd_valid, i_cmd_addr, i_cmd_len, i_cmd_write, i_cmd_size,
    output i_wr_data, i_wr_valid, i_rd_ready,
    output i_xfer_adv, i_xfer_rdata, i_xfer_rdav, i_xfer_ok_to_shutdown,
    input  o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid, o_done,
    input  o_xfer_wdata, o_xfer_addr, o_xfer_size, o_xfer_write,
    input  o_xfer_dav, o_xfer_full, o_xfer_trig, o_xfer_en,
    input  o_xfer_prot, o_xfer_lock
  );

endinterface : ahb_xfer_sequencer_if
`default_nettype wire

// File: rtl/ahb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sync_fifo
//  Description : Single-clock FIFO, WDT x DEPTH (DEPTH a power of two).
//                Pop on empty is ignored; push on full is dropped unless a
//                pop happens in the same cycle. Head reads as zero when empty
//                so nothing ever passes straight through an empty FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_sync_fifo #(
  parameter int WDT   = 32,
  parameter int DEPTH = 8
) (
  input  wire logic                       i_clk,
  input  wire logic                       i_rst,
  input  wire logic                       i_push,
  input  wire logic [WDT-1:0]             i_data,
  input  wire logic                       i_pop,
  output logic      [WDT-1:0]             o_data,
  output logic                            o_full,
  output logic                            o_empty,
  output logic      [$clog2(DEPTH):0]     o_free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];

  logic [WDT-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Storage array; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_free  = C_DEPTH - r_count;

endmodule : ahb_sync_fifo
`default_nettype wire

// File: rtl/ahb_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_xfer_sequencer
//  Description : Turns a (addr, len, dir, size) command into one AHB burst
//                through an AHB master user interface, buffering write data
//                and read data in two small FIFOs.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_xfer_sequencer
  import ahb_master_pkg::*;
#(
  parameter int BUS_WDT    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input wire logic             i_hclk,
  input wire logic             i_hreset,
  ahb_xfer_sequencer_if.slave  io_bus
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  // Read FIFO must keep two free slots: one beat may be in the AHB data
  // phase and another in the address phase when the master is stopped.
  localparam logic [FAW:0] C_FREE_MARGIN = 2;

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic [31:0]          r_addr;
  logic [C_LEN_WDT-1:0] r_len;
  logic [C_LEN_WDT-1:0] r_issued;
  logic [C_LEN_WDT-1:0] r_received;
  logic                 r_write;
  logic [1:0]           r_size;

  logic w_cmd_acc;
  logic w_beat;
  logic w_last_beat;
  logic w_xfer_dav;
  logic w_xfer_full;
  logic w_cmd_ready;
  logic w_xfer_en;
  logic w_xfer_trig;
  logic w_done;

  logic [BUS_WDT-1:0] w_wf_data;
  logic               w_wf_full;
  logic               w_wf_empty;
  logic [FAW:0]       w_wf_free;
  logic [BUS_WDT-1:0] w_rf_data;
  logic               w_rf_full;
  logic               w_rf_empty;
  logic [FAW:0]       w_rf_free;
  logic               w_unused;

  assign w_cmd_acc   = io_bus.i_cmd_valid && (r_state == ST_IDLE);
  assign w_xfer_dav  = r_write && !w_wf_empty;
  assign w_xfer_full = !r_write && (w_rf_full || (w_rf_free < C_FREE_MARGIN));
  assign w_beat      = is_issue_state(r_state) && io_bus.i_xfer_adv &&
                       (r_write ? w_xfer_dav : !w_xfer_full);
  assign w_last_beat = w_beat && ((r_issued + 16'd1) == r_len);
  assign w_unused    = &{1'b0, w_wf_free};

  // Write data: stream in, popped by every issued write beat
  ahb_sync_fifo #(
    .WDT   (BUS_WDT),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .i_clk   (i_hclk),
    .i_rst   (i_hreset),
    .i_push  (io_bus.i_wr_valid && !w_wf_full),
    .i_data  (io_bus.i_wr_data),
    .i_pop   (w_beat && r_write),
    .o_data  (w_wf_data),
    .o_full  (w_wf_full),
    .o_empty (w_wf_empty),
    .o_free  (w_wf_free)
  );

  // Read data: pushed by the master, popped by the read stream consumer
  ahb_sync_fifo #(
    .WDT   (BUS_WDT),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .i_clk   (i_hclk),
    .i_rst   (i_hreset),
    .i_push  (io_bus.i_xfer_rdav),
    .i_data  (io_bus.i_xfer_rdata),
    .i_pop   (io_bus.i_rd_ready),
    .o_data  (w_rf_data),
    .o_full  (w_rf_full),
    .o_empty (w_rf_empty),
    .o_free  (w_rf_free)
  );

  // FSM state register
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_xfer_en   = 1'b0;
    w_xfer_trig = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = 1'b1;
        if (w_cmd_acc) begin
          w_state_nxt = (io_bus.i_cmd_len == 16'd0) ? ST_DONE : ST_START;
        end
      end
      ST_START: begin
        w_xfer_en   = 1'b1;
        w_xfer_trig = 1'b1;
        if (w_last_beat) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_beat) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_xfer_en = 1'b1;
        if (w_last_beat) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (io_bus.i_xfer_ok_to_shutdown && (r_write || (r_received == r_len))) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latches and beat counters
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_issued   <= '0;
      r_received <= '0;
    end else if (w_cmd_acc) begin
      r_addr     <= io_bus.i_cmd_addr;
      r_len      <= io_bus.i_cmd_len;
      r_write    <= io_bus.i_cmd_write;
      r_size     <= io_bus.i_cmd_size;
      r_issued   <= '0;
      r_received <= '0;
    end else begin
      if (w_beat) begin
        r_issued <= r_issued + 16'd1;
      end
      if (io_bus.i_xfer_rdav) begin
        r_received <= r_received + 16'd1;
      end
    end
  end

  assign io_bus.o_cmd_ready  = w_cmd_ready;
  // Held low while reset is asserted so the stream sees no acceptance
  assign io_bus.o_wr_ready   = !w_wf_full && !i_hreset;
  assign io_bus.o_rd_data    = w_rf_data;
  assign io_bus.o_rd_valid   = !w_rf_empty;
  assign io_bus.o_done       = w_done;
  assign io_bus.o_xfer_wdata = w_wf_data;
  assign io_bus.o_xfer_addr  = r_addr;
  assign io_bus.o_xfer_size  = r_size;
  assign io_bus.o_xfer_write = r_write;
  assign io_bus.o_xfer_dav   = w_xfer_dav;
  assign io_bus.o_xfer_full  = w_xfer_full;
  assign io_bus.o_xfer_trig  = w_xfer_trig;
  assign io_bus.o_xfer_en    = w_xfer_en;
  assign io_bus.o_xfer_prot  = C_XFER_PROT;
  assign io_bus.o_xfer_lock  = 1'b0;

endmodule : ahb_xfer_sequencer
`default_nettype wire

// File: tb/tb_ahb_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_xfer_sequencer
//  Description : Directed self-checking bench for ahb_xfer_sequencer
//                (FIFO_DEPTH=4). Inputs change 1 time unit after the rising
//                edge; outputs are sampled 2 units after the edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_xfer_sequencer;

  localparam int C_BW    = 32;
  localparam int C_DEPTH = 4;

  logic r_clk = 1'b0;
  logic r_rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_beats;

  always #5 r_clk = ~r_clk;

  ahb_xfer_sequencer_if #(.BUS_WDT(C_BW)) u_bus ();

  ahb_xfer_sequencer #(
    .BUS_WDT    (C_BW),
    .FIFO_DEPTH (C_DEPTH)
  ) u_dut (
    .i_hclk   (r_clk),
    .i_hreset (r_rst),
    .io_bus   (u_bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge r_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [15:0] len, input logic wr);
    u_bus.i_cmd_valid = 1'b1;
    u_bus.i_cmd_addr  = addr;
    u_bus.i_cmd_len   = len;
    u_bus.i_cmd_write = wr;
    u_bus.i_cmd_size  = 2'd2;
    settle();
    check_eq("cmd_ready_at_accept", u_bus.o_cmd_ready, 1'b1);
    next_cycle();
    u_bus.i_cmd_valid = 1'b0;
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    u_bus.i_cmd_valid = 1'b0;
    u_bus.i_cmd_addr  = '0;
    u_bus.i_cmd_len   = '0;
    u_bus.i_cmd_write = 1'b0;
    u_bus.i_cmd_size  = '0;
    u_bus.i_wr_data   = '0;
    u_bus.i_wr_valid  = 1'b0;
    u_bus.i_rd_ready  = 1'b0;
    u_bus.i_xfer_adv  = 1'b0;
    u_bus.i_xfer_rdata = '0;
    u_bus.i_xfer_rdav = 1'b0;
    u_bus.i_xfer_ok_to_shutdown = 1'b0;
    r_rst = 1'b1;
    #2;

    // ---------------- reset state
    check_eq("rst_cmd_ready", u_bus.o_cmd_ready, 1'b1);
    check_eq("rst_prot",      u_bus.o_xfer_prot, 4'b0011);
    check_eq("rst_lock",      u_bus.o_xfer_lock, 1'b0);
    check_eq("rst_wr_ready",  u_bus.o_wr_ready,  1'b0);
    check_eq("rst_en",        u_bus.o_xfer_en,   1'b0);
    check_eq("rst_done",      u_bus.o_done,      1'b0);
    check_eq("rst_rd_valid",  u_bus.o_rd_valid,  1'b0);
    check_eq("rst_addr",      u_bus.o_xfer_addr, 32'h0);
    repeat (2) next_cycle();
    r_rst = 1'b0;
    settle();
    check_eq("post_rst_wr_ready", u_bus.o_wr_ready, 1'b1);

    // ---------------- write addr=0x100 len=4, 4 words pre-loaded, adv=1
    for (int i = 0; i < 4; i++) begin
      u_bus.i_wr_valid = 1'b1;
      u_bus.i_wr_data  = 32'hA0 + i;
      next_cycle();
    end
    u_bus.i_wr_valid = 1'b0;
    settle();
    check_eq("w4_wr_ready_full", u_bus.o_wr_ready, 1'b0);
    check_eq("w4_dav_idle",      u_bus.o_xfer_dav, 1'b0);
    u_bus.i_xfer_adv = 1'b1;
    send_cmd(32'h100, 16'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("w4_trig",  u_bus.o_xfer_trig,  (i == 0));
      check_eq("w4_en",    u_bus.o_xfer_en,    1'b1);
      check_eq("w4_dav",   u_bus.o_xfer_dav,   1'b1);
      check_eq("w4_wdata", u_bus.o_xfer_wdata, 32'hA0 + i);
      if (i == 0) begin
        check_eq("w4_addr",  u_bus.o_xfer_addr,  32'h100);
        check_eq("w4_size",  u_bus.o_xfer_size,  2'd2);
        check_eq("w4_write", u_bus.o_xfer_write, 1'b1);
      end
      next_cycle();
      settle();
    end
    check_eq("w4_drain_en",   u_bus.o_xfer_en,   1'b0);
    check_eq("w4_drain_dav",  u_bus.o_xfer_dav,  1'b0);
    check_eq("w4_drain_trig", u_bus.o_xfer_trig, 1'b0);
    check_eq("w4_drain_done", u_bus.o_done,      1'b0);
    check_eq("w4_wr_ready",   u_bus.o_wr_ready,  1'b1);
    next_cycle();
    settle();
    check_eq("w4_wait_done",  u_bus.o_done,      1'b0);
    check_eq("w4_wait_ready", u_bus.o_cmd_ready, 1'b0);
    u_bus.i_xfer_ok_to_shutdown = 1'b1;
    next_cycle();
    u_bus.i_xfer_ok_to_shutdown = 1'b0;
    settle();
    check_eq("w4_done",  u_bus.o_done, 1'b1);
    next_cycle();
    settle();
    check_eq("w4_done_end", u_bus.o_done,      1'b0);
    check_eq("w4_idle",     u_bus.o_cmd_ready, 1'b1);

    // ---------------- write len=2, stream stalls after first beat
    u_bus.i_wr_valid = 1'b1;
    u_bus.i_wr_data  = 32'hB0;
    next_cycle();
    u_bus.i_wr_valid = 1'b0;
    n_beats = 0;
    send_cmd(32'h300, 16'd2, 1'b1);
    check_eq("w2_trig",  u_bus.o_xfer_trig,  1'b1);
    check_eq("w2_wdata", u_bus.o_xfer_wdata, 32'hB0);
    if (u_bus.i_xfer_adv && u_bus.o_xfer_dav && u_bus.o_xfer_en) n_beats++;
    next_cycle();
    settle();
    for (int i = 0; i < 5; i++) begin
      check_eq("w2_stall_dav", u_bus.o_xfer_dav, 1'b0);
      check_eq("w2_stall_en",  u_bus.o_xfer_en,  1'b1);
      if (u_bus.i_xfer_adv && u_bus.o_xfer_dav && u_bus.o_xfer_en) n_beats++;
      if (i == 4) begin
        u_bus.i_wr_valid = 1'b1;
        u_bus.i_wr_data  = 32'hB1;
      end
      next_cycle();
      u_bus.i_wr_valid = 1'b0;
      settle();
    end
    check_eq("w2_dav2",   u_bus.o_xfer_dav,   1'b1);
    check_eq("w2_wdata2", u_bus.o_xfer_wdata, 32'hB1);
    if (u_bus.i_xfer_adv && u_bus.o_xfer_dav && u_bus.o_xfer_en) n_beats++;
    next_cycle();
    settle();
    check_eq("w2_drain_en",  u_bus.o_xfer_en,  1'b0);
    check_eq("w2_drain_dav", u_bus.o_xfer_dav, 1'b0);
    check_eq("w2_beats",     n_beats,          2);
    u_bus.i_xfer_ok_to_shutdown = 1'b1;
    next_cycle();
    u_bus.i_xfer_ok_to_shutdown = 1'b0;
    settle();
    check_eq("w2_done", u_bus.o_done, 1'b1);
    next_cycle();
    settle();

    // ---------------- read len=3, consumer stalled, full margin
    send_cmd(32'h200, 16'd3, 1'b0);
    check_eq("r3_trig", u_bus.o_xfer_trig, 1'b1);
    check_eq("r3_full0", u_bus.o_xfer_full, 1'b0);
    next_cycle();
    u_bus.i_xfer_rdav  = 1'b1;
    u_bus.i_xfer_rdata = 32'hC0;
    settle();
    check_eq("r3_full_e0", u_bus.o_xfer_full, 1'b0);
    next_cycle();
    u_bus.i_xfer_rdata = 32'hC1;
    settle();
    check_eq("r3_full_e1", u_bus.o_xfer_full, 1'b0);
    next_cycle();
    u_bus.i_xfer_rdata = 32'hC2;
    u_bus.i_xfer_ok_to_shutdown = 1'b1;
    settle();
    check_eq("r3_drain_en", u_bus.o_xfer_en,   1'b0);
    check_eq("r3_full_e2",  u_bus.o_xfer_full, 1'b0);
    next_cycle();
    u_bus.i_xfer_rdav = 1'b0;
    settle();
    check_eq("r3_full_e3",   u_bus.o_xfer_full, 1'b1);
    check_eq("r3_wait_rcv",  u_bus.o_done,      1'b0);
    check_eq("r3_rd_valid",  u_bus.o_rd_valid,  1'b1);
    check_eq("r3_rd_head",   u_bus.o_rd_data,   32'hC0);
    next_cycle();
    u_bus.i_xfer_ok_to_shutdown = 1'b0;
    settle();
    check_eq("r3_done", u_bus.o_done, 1'b1);
    next_cycle();
    u_bus.i_rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("r3_pop_valid", u_bus.o_rd_valid, 1'b1);
      check_eq("r3_pop_data",  u_bus.o_rd_data,  32'hC0 + i);
      next_cycle();
    end
    u_bus.i_rd_ready = 1'b0;
    settle();
    check_eq("r3_empty",     u_bus.o_rd_valid,  1'b0);
    check_eq("r3_full_free", u_bus.o_xfer_full, 1'b0);

    // ---------------- zero-length command
    send_cmd(32'h400, 16'd0, 1'b0);
    check_eq("z_done",  u_bus.o_done,      1'b1);
    check_eq("z_en",    u_bus.o_xfer_en,   1'b0);
    check_eq("z_ready", u_bus.o_cmd_ready, 1'b0);
    next_cycle();
    settle();
    check_eq("z_done_end", u_bus.o_done,      1'b0);
    check_eq("z_en_end",   u_bus.o_xfer_en,   1'b0);
    check_eq("z_idle",     u_bus.o_cmd_ready, 1'b1);

    // ---------------- reset in the middle of a read len=8
    for (int i = 0; i < 4; i++) begin
      u_bus.i_wr_valid = 1'b1;
      u_bus.i_wr_data  = 32'hE0 + i;
      next_cycle();
    end
    u_bus.i_wr_valid = 1'b0;
    settle();
    check_eq("mr_wf_full", u_bus.o_wr_ready, 1'b0);
    send_cmd(32'h500, 16'd8, 1'b0);
    next_cycle();
    u_bus.i_xfer_rdav  = 1'b1;
    u_bus.i_xfer_rdata = 32'hD0;
    next_cycle();
    u_bus.i_xfer_rdata = 32'hD1;
    next_cycle();
    u_bus.i_xfer_rdav = 1'b0;
    settle();
    check_eq("mr_pre_en",       u_bus.o_xfer_en,  1'b1);
    check_eq("mr_pre_rd_valid", u_bus.o_rd_valid, 1'b1);
    r_rst = 1'b1;
    settle();
    check_eq("mr_rst_ready",    u_bus.o_cmd_ready, 1'b1);
    check_eq("mr_rst_en",       u_bus.o_xfer_en,   1'b0);
    check_eq("mr_rst_trig",     u_bus.o_xfer_trig, 1'b0);
    check_eq("mr_rst_rd_valid", u_bus.o_rd_valid,  1'b0);
    check_eq("mr_rst_wr_ready", u_bus.o_wr_ready,  1'b0);
    check_eq("mr_rst_addr",     u_bus.o_xfer_addr, 32'h0);
    check_eq("mr_rst_prot",     u_bus.o_xfer_prot, 4'b0011);
    next_cycle();
    r_rst = 1'b0;
    u_bus.i_xfer_adv = 1'b0;
    settle();
    check_eq("mr_wf_empty", u_bus.o_wr_ready,   1'b1);
    check_eq("mr_rf_empty", u_bus.o_rd_valid,   1'b0);
    check_eq("mr_rd_data",  u_bus.o_rd_data,    32'h0);
    check_eq("mr_wdata",    u_bus.o_xfer_wdata, 32'h0);
    check_eq("mr_idle",     u_bus.o_cmd_ready,  1'b1);
    check_eq("mr_done",     u_bus.o_done,       1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_ahb_xfer_sequencer
`default_nettype wire
